// File: rtl/svm_mac_sequencer.sv
// SVM MAC operand sequencer.
// Walks every (instance, support vector, feature) triple once per run and
// drives the memory row/column indices. It also generates the MAC control
// strobes, which are aligned to the fixed one-cycle memory read latency.
module svm_mac_sequencer #(
    parameter int unsigned NUM_FEAT = 2,
    parameter int unsigned NUM_SV   = 3,
    parameter int unsigned NUM_INST = 2,
    localparam int unsigned IW = (NUM_INST > 1) ? $clog2(NUM_INST) : 1,
    localparam int unsigned SW = (NUM_SV > 1) ? $clog2(NUM_SV) : 1,
    localparam int unsigned FW = (NUM_FEAT > 1) ? $clog2(NUM_FEAT) : 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          go,
    input  logic          hold,
    output logic [IW-1:0] inst_idx,
    output logic [SW-1:0] sv_idx,
    output logic [FW-1:0] feat_idx,
    output logic          addr_valid,
    output logic          mac_en,
    output logic          mac_clr,
    output logic          mac_last,
    output logic          rc_start,
    output logic          busy,
    output logic          done
);

    localparam logic [IW-1:0] INST_MAX = IW'(NUM_INST - 1);
    localparam logic [SW-1:0] SV_MAX   = SW'(NUM_SV - 1);
    localparam logic [FW-1:0] FEAT_MAX = FW'(NUM_FEAT - 1);

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDrain,
        StDone
    } state_e;

    state_e        state_q;
    logic [IW-1:0] inst_q;
    logic [SW-1:0] sv_q;
    logic [FW-1:0] feat_q;
    logic          mac_en_q;
    logic          mac_clr_q;
    logic          mac_last_q;
    logic          rc_start_q;
    logic          first_q;     // no issue has happened yet in this run
    logic          busy_q;
    logic          done_q;
    logic          issue;

    // An issue happens on every unstalled RUN cycle; this is the only
    // combinational output so the memory sees the address in the same cycle.
    assign issue = (state_q == StRun) && !hold;

    // Control FSM, index counters and registered MAC strobes.
    // Strobes are sampled from the issuing cycle so they line up with the
    // read data that arrives one cycle later.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= StIdle;
            inst_q     <= '0;
            sv_q       <= '0;
            feat_q     <= '0;
            mac_en_q   <= 1'b0;
            mac_clr_q  <= 1'b0;
            mac_last_q <= 1'b0;
            rc_start_q <= 1'b0;
            first_q    <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            mac_en_q   <= issue;
            mac_clr_q  <= issue && (feat_q == '0);
            mac_last_q <= issue && (feat_q == FEAT_MAX);
            rc_start_q <= issue && first_q;
            done_q     <= 1'b0;

            unique case (state_q)
                StIdle: begin
                    if (go) begin
                        state_q <= StRun;
                        busy_q  <= 1'b1;
                        first_q <= 1'b1;
                        inst_q  <= '0;
                        sv_q    <= '0;
                        feat_q  <= '0;
                    end
                end

                StRun: begin
                    if (!hold) begin
                        first_q <= 1'b0;
                        // Feature innermost, instance outermost; the final
                        // carry out of the instance counter ends the run.
                        if (feat_q == FEAT_MAX) begin
                            feat_q <= '0;
                            if (sv_q == SV_MAX) begin
                                sv_q <= '0;
                                if (inst_q == INST_MAX) begin
                                    inst_q  <= '0;
                                    state_q <= StDrain;
                                end else begin
                                    inst_q <= inst_q + 1'b1;
                                end
                            end else begin
                                sv_q <= sv_q + 1'b1;
                            end
                        end else begin
                            feat_q <= feat_q + 1'b1;
                        end
                    end
                end

                // The last read returns here; hold has no effect.
                StDrain: begin
                    state_q <= StDone;
                    done_q  <= 1'b1;
                end

                StDone: begin
                    state_q <= StIdle;
                    busy_q  <= 1'b0;
                end

                default: begin
                    state_q <= StIdle;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign addr_valid = issue;
    assign inst_idx   = inst_q;
    assign sv_idx     = sv_q;
    assign feat_idx   = feat_q;
    assign mac_en     = mac_en_q;
    assign mac_clr    = mac_clr_q;
    assign mac_last   = mac_last_q;
    assign rc_start   = rc_start_q;
    assign busy       = busy_q;
    assign done       = done_q;

endmodule

// File: tb/tb_svm_mac_sequencer.sv
// Directed testbench for svm_mac_sequencer (default 2/3/2 geometry plus a
// 1/1/1 instance). Cycle n is the interval after clock edge n-1; outputs are
// sampled on the falling edge in the middle of each cycle.
module tb_svm_mac_sequencer;

    logic       clk;
    logic       rst;
    logic       go;
    logic       hold;
    logic [0:0] inst_idx;
    logic [1:0] sv_idx;
    logic [0:0] feat_idx;
    logic       addr_valid, mac_en, mac_clr, mac_last, rc_start, busy, done;

    logic       go1;
    logic [0:0] inst_idx1, sv_idx1, feat_idx1;
    logic       addr_valid1, mac_en1, mac_clr1, mac_last1, rc_start1, busy1, done1;

    int checks;
    int failures;

    // {inst, sv, feat, addr_valid, mac_en, mac_clr, mac_last, rc_start, busy, done}
    logic [10:0] obs;
    logic [9:0]  obs1;
    assign obs  = {inst_idx, sv_idx, feat_idx, addr_valid, mac_en, mac_clr, mac_last,
                   rc_start, busy, done};
    assign obs1 = {inst_idx1, sv_idx1, feat_idx1, addr_valid1, mac_en1, mac_clr1,
                   mac_last1, rc_start1, busy1, done1};

    svm_mac_sequencer #(.NUM_FEAT(2), .NUM_SV(3), .NUM_INST(2)) dut (
        .clk(clk), .rst(rst), .go(go), .hold(hold),
        .inst_idx(inst_idx), .sv_idx(sv_idx), .feat_idx(feat_idx),
        .addr_valid(addr_valid), .mac_en(mac_en), .mac_clr(mac_clr),
        .mac_last(mac_last), .rc_start(rc_start), .busy(busy), .done(done)
    );

    svm_mac_sequencer #(.NUM_FEAT(1), .NUM_SV(1), .NUM_INST(1)) dut1 (
        .clk(clk), .rst(rst), .go(go1), .hold(1'b0),
        .inst_idx(inst_idx1), .sv_idx(sv_idx1), .feat_idx(feat_idx1),
        .addr_valid(addr_valid1), .mac_en(mac_en1), .mac_clr(mac_clr1),
        .mac_last(mac_last1), .rc_start(rc_start1), .busy(busy1), .done(done1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // Expected outputs in cycle c of an unstalled run started by go at edge 0.
    function automatic logic [10:0] exp_plain(input int c);
        logic av, me, clr, last, rc, bsy, dn;
        logic [3:0] idx;
        int k;
        av   = (c >= 1) && (c <= 12);
        me   = (c >= 2) && (c <= 13);
        clr  = me && (c % 2 == 0);
        last = me && (c % 2 == 1);
        rc   = (c == 2);
        bsy  = (c >= 1) && (c <= 14);
        dn   = (c == 14);
        k    = av ? c - 1 : 0;
        idx  = {1'(k / 6), 2'((k / 2) % 3), 1'(k % 2)};
        return {idx, av, me, clr, last, rc, bsy, dn};
    endfunction

    task automatic test_reset;
        rst = 1'b1; go = 1'b0; hold = 1'b0; go1 = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if (obs !== 11'd0) begin
            failures++;
            $display("FAIL reset_main got=%b exp=%b", obs, 11'd0);
        end
        checks++;
        if (obs1 !== 10'd0) begin
            failures++;
            $display("FAIL reset_small got=%b exp=%b", obs1, 10'd0);
        end
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (obs !== 11'd0) begin
            failures++;
            $display("FAIL idle_after_release got=%b exp=%b", obs, 11'd0);
        end
    endtask

    task automatic test_basic;
        logic [10:0] e;
        @(negedge clk);
        go = 1'b1; hold = 1'b0;
        for (int c = 1; c <= 16; c++) begin
            @(posedge clk); #1 go = 1'b0;
            @(negedge clk);
            e = exp_plain(c);
            checks++;
            if (obs !== e) begin
                failures++;
                $display("FAIL basic cyc=%0d got=%b exp=%b", c, obs, e);
            end
        end
    endtask

    task automatic test_hold;
        logic [10:0] e;
        logic [3:0]  idx;
        logic        av, me, clr, last;
        int          k, kp, issues;
        issues = 0;
        @(negedge clk);
        go = 1'b1; hold = 1'b0;
        for (int c = 1; c <= 19; c++) begin
            @(posedge clk); #1 go = 1'b0; hold = (c >= 4) && (c <= 6);
            @(negedge clk);
            av   = (c <= 3) || ((c >= 7) && (c <= 15));
            k    = (c <= 3) ? c - 1 : (c <= 6) ? 3 : (c <= 15) ? c - 4 : 0;
            idx  = {1'(k / 6), 2'((k / 2) % 3), 1'(k % 2)};
            me   = ((c >= 2) && (c <= 4)) || ((c >= 8) && (c <= 16));
            kp   = (c - 1 <= 3) ? c - 2 : c - 5;
            clr  = me && (kp % 2 == 0);
            last = me && (kp % 2 == 1);
            e    = {idx, av, me, clr, last, c == 2, c <= 17, c == 17};
            if (addr_valid === 1'b1) issues++;
            checks++;
            if (obs !== e) begin
                failures++;
                $display("FAIL hold cyc=%0d got=%b exp=%b", c, obs, e);
            end
        end
        hold = 1'b0;
        checks++;
        if (issues !== 12) begin
            failures++;
            $display("FAIL hold_issue_count got=%0d exp=12", issues);
        end
    endtask

    task automatic test_drain_hold;
        logic [10:0] e;
        @(negedge clk);
        go = 1'b1; hold = 1'b0;
        for (int c = 1; c <= 16; c++) begin
            @(posedge clk); #1 go = 1'b0; hold = (c == 13) || (c == 14);
            @(negedge clk);
            e = exp_plain(c);
            checks++;
            if (obs !== e) begin
                failures++;
                $display("FAIL drain_hold cyc=%0d got=%b exp=%b", c, obs, e);
            end
        end
        hold = 1'b0;
    endtask

    task automatic test_back_to_back;
        logic [10:0] e;
        @(negedge clk);
        go = 1'b1; hold = 1'b0;
        for (int c = 1; c <= 31; c++) begin
            @(posedge clk); #1 go = (c <= 20);
            @(negedge clk);
            e = exp_plain((c <= 15) ? c : c - 15);
            checks++;
            if (obs !== e) begin
                failures++;
                $display("FAIL back_to_back cyc=%0d got=%b exp=%b", c, obs, e);
            end
        end
        go = 1'b0;
    endtask

    task automatic test_async_reset;
        logic [10:0] e;
        @(negedge clk);
        go = 1'b1; hold = 1'b0;
        for (int c = 1; c <= 7; c++) begin
            @(posedge clk); #1 go = 1'b0;
            @(negedge clk);
            e = exp_plain(c);
            checks++;
            if (obs !== e) begin
                failures++;
                $display("FAIL pre_reset cyc=%0d got=%b exp=%b", c, obs, e);
            end
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if (obs !== 11'd0) begin
            failures++;
            $display("FAIL async_reset_immediate got=%b exp=%b", obs, 11'd0);
        end
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (obs !== 11'd0) begin
            failures++;
            $display("FAIL in_reset got=%b exp=%b", obs, 11'd0);
        end
        // Release and request a run on the very first edge afterwards.
        rst = 1'b0;
        go  = 1'b1;
        for (int c = 1; c <= 16; c++) begin
            @(posedge clk); #1 go = 1'b0;
            @(negedge clk);
            e = exp_plain(c);
            checks++;
            if (obs !== e) begin
                failures++;
                $display("FAIL restart cyc=%0d got=%b exp=%b", c, obs, e);
            end
        end
    endtask

    task automatic test_single_term;
        logic [9:0] e;
        @(negedge clk);
        go1 = 1'b1;
        for (int c = 1; c <= 4; c++) begin
            @(posedge clk); #1 go1 = 1'b0;
            @(negedge clk);
            case (c)
                1:       e = 10'b000_1000010;
                2:       e = 10'b000_0111110;
                3:       e = 10'b000_0000011;
                default: e = 10'b000_0000000;
            endcase
            checks++;
            if (obs1 !== e) begin
                failures++;
                $display("FAIL single_term cyc=%0d got=%b exp=%b", c, obs1, e);
            end
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        test_reset();
        test_basic();
        test_hold();
        test_drain_hold();
        test_back_to_back();
        test_async_reset();
        test_single_term();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/svm_mac_sequencer.md
SVM_MAC_SEQUENCER -- requirements
Module: svm_mac_sequencer

Interface
REQ-001 Parameter NUM_FEAT, default 2, features per vector (>=1).
REQ-002 Parameter NUM_SV, default 3, support vectors (>=1).
REQ-003 Parameter NUM_INST, default 2, instances classified per run (>=1).
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 rst  input  1  reset; asynchronous, active-high.
REQ-006 go  input  1  start request; sampled only in IDLE.
REQ-007 hold  input  1  stall; freezes operand issue while high.
REQ-008 inst_idx  output  max(1,$clog2(NUM_INST))  instance memory row for current issue.
REQ-009 sv_idx  output  max(1,$clog2(NUM_SV))  support-vector memory row for current issue.
REQ-010 feat_idx  output  max(1,$clog2(NUM_FEAT))  feature column for current issue.
REQ-011 addr_valid  output  1  indices valid this cycle (an issue occurs).
REQ-012 mac_en  output  1  MAC accumulate enable; operands present from memory.
REQ-013 mac_clr  output  1  first term of a dot product; MAC loads instead of accumulating.
REQ-014 mac_last  output  1  last term of a dot product.
REQ-015 rc_start  output  1  one-cycle pulse with the first mac_en of a run.
REQ-016 busy  output  1  high in any state other than IDLE.
REQ-017 done  output  1  one-cycle completion pulse.

Function
REQ-018 States IDLE, RUN, DRAIN, DONE; encoding free.
REQ-019 IDLE: go=1 -> RUN, counters cleared to 0; go=0 -> stay.
REQ-020 RUN: addr_valid = !hold (combinational from state and hold); all other outputs registered.
REQ-021 Issue order: feat_idx innermost, then sv_idx, then inst_idx outermost; each wraps to 0 at limit-1 and carries outward.
REQ-022 An issue (RUN, hold=0) advances counters by one step; hold=1 holds all counters and the state.
REQ-023 Issue with inst_idx=NUM_INST-1, sv_idx=NUM_SV-1, feat_idx=NUM_FEAT-1 -> DRAIN next cycle; counters return to 0.
REQ-024 Total issues per run exactly NUM_INST*NUM_SV*NUM_FEAT; hold only inserts gaps.
REQ-025 Memory latency fixed at 1: mac_en equals previous cycle's addr_valid.
REQ-026 mac_clr/mac_last: registered with mac_en, high when the issuing cycle had feat_idx=0 / feat_idx=NUM_FEAT-1; both high together when NUM_FEAT=1.
REQ-027 rc_start high with the first mac_en after leaving IDLE only; never repeated within a run.
REQ-028 DRAIN: one cycle, hold ignored, emits the final mac_en -> DONE.
REQ-029 DONE: done=1 for exactly one cycle -> IDLE; go in DONE ignored.
REQ-030 go while busy ignored; no queueing.
REQ-031 In IDLE/DRAIN/DONE, addr_valid=0; indices read 0.

Reset
REQ-032 rst=1 forces IDLE immediately regardless of clk; all outputs 0, counters 0.
REQ-033 Reset mid-run abandons the run; no done pulse; first clk edge after release is in IDLE.
REQ-034 go high on the first edge after reset release starts a run normally.

Verification (NUM_FEAT=2, NUM_SV=3, NUM_INST=2)
REQ-035 go pulse edge 0, hold=0 -> addr_valid cycles 1-12; indices (i,s,f) (0,0,0),(0,0,1),(0,1,0)...(1,2,1); mac_en cycles 2-13; mac_clr cycles 2,4,...,12; mac_last 3,5,...,13; rc_start cycle 2 only; done cycle 14; busy cycles 1-14.
REQ-036 hold=1 during cycles 4-6 -> addr_valid low 4-6, indices frozen at (0,1,1), mac_en low 5-7; 12 issues total; done cycle 17.
REQ-037 go held high continuously -> second run starts only after returning to IDLE (RUN re-entered cycle 16); go during busy has no effect.
REQ-038 rst asserted asynchronously in cycle 7 -> all outputs 0 immediately; no done; next go restarts at (0,0,0).
REQ-039 Params NUM_FEAT=1, NUM_SV=1, NUM_INST=1, go edge 0 -> single issue cycle 1; mac_en, mac_clr, mac_last, rc_start all high cycle 2; done cycle 3.
REQ-040 hold=1 while in DRAIN -> ignored; done timing unchanged from REQ-035.
